// File: rtl/spi_frame_receiver.sv
// Receive side of the 3-wire serial link: oversamples CS/SCLK/SDI in the CLK domain and
// deserialises one WIDTH-bit word per chip-select frame (LSB first) onto a valid/ready port.
module spi_frame_receiver #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             P_CS_N,
    input  logic             P_SDI,
    input  logic             P_SCLK,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic [CNT_W-1:0] frame_count
);

    localparam int BC_W = $clog2(WIDTH + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);
    localparam logic [BC_W-1:0] BC_ONE  = {{(BC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] sdi_sync_r;
    logic [SYNC_STAGES-1:0] fill_r;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   sdi_s;
    logic                   cs_prev_r;
    logic                   sclk_prev_r;
    logic                   armed_r;
    logic                   cs_fall_r;
    logic                   cs_rise_r;
    logic                   sclk_fall_r;
    logic                   sdi_d_r;

    state_t                 state_r;
    state_t                 state_s;
    logic                   start_s;
    logic                   shift_en_s;
    logic                   extra_set_s;
    logic                   err_s;
    logic                   complete_s;
    logic                   load_s;
    logic                   drop_s;

    logic [WIDTH-1:0]       shift_r;
    logic [BC_W-1:0]        bit_cnt_r;
    logic                   extra_r;
    logic [WIDTH-1:0]       data_out_r;
    logic                   data_valid_r;
    logic                   frame_err_r;
    logic                   overflow_r;
    logic [CNT_W-1:0]       frame_count_r;

    assign cs_s   = cs_sync_r[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync_r[SYNC_STAGES-1];

    // Pin synchronisers; fill_r marks when the CS chain holds real pin samples rather than reset values
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            sdi_sync_r  <= {SYNC_STAGES{1'b0}};
            fill_r      <= {SYNC_STAGES{1'b0}};
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], P_CS_N};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], P_SCLK};
            sdi_sync_r  <= {sdi_sync_r[SYNC_STAGES-2:0], P_SDI};
            fill_r      <= {fill_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Registered edge strobes; a CS fall only counts once CS has been seen high since reset,
    // so a frame interrupted by reset is never picked up half-way through
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cs_prev_r   <= 1'b1;
            sclk_prev_r <= 1'b0;
            armed_r     <= 1'b0;
            cs_fall_r   <= 1'b0;
            cs_rise_r   <= 1'b0;
            sclk_fall_r <= 1'b0;
            sdi_d_r     <= 1'b0;
        end else begin
            cs_prev_r   <= cs_s;
            sclk_prev_r <= sclk_s;
            armed_r     <= armed_r | (fill_r[SYNC_STAGES-1] & cs_s);
            cs_fall_r   <= armed_r & cs_prev_r & ~cs_s;
            cs_rise_r   <= ~cs_prev_r & cs_s;
            sclk_fall_r <= sclk_prev_r & ~sclk_s;
            sdi_d_r     <= sdi_s;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cs_fall_r) begin
                    state_s = RECV;
                end else begin
                    state_s = IDLE;
                end
            end
            RECV: begin
                if (cs_rise_r) begin
                    state_s = IDLE;
                end else if (sclk_fall_r && (bit_cnt_r == BC_LAST)) begin
                    state_s = FULL;
                end else begin
                    state_s = RECV;
                end
            end
            FULL: begin
                if (cs_rise_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = FULL;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM output strobes
    always_comb begin
        start_s     = 1'b0;
        shift_en_s  = 1'b0;
        extra_set_s = 1'b0;
        err_s       = 1'b0;
        complete_s  = 1'b0;
        case (state_r)
            IDLE: begin
                start_s = cs_fall_r;
            end
            RECV: begin
                shift_en_s = sclk_fall_r & ~cs_rise_r;
                err_s      = cs_rise_r;
            end
            FULL: begin
                extra_set_s = sclk_fall_r & ~cs_rise_r;
                err_s       = cs_rise_r & extra_r;
                complete_s  = cs_rise_r & ~extra_r;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // Shift register, bit counter and long-frame flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {BC_W{1'b0}};
            extra_r   <= 1'b0;
        end else if (start_s) begin
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {BC_W{1'b0}};
            extra_r   <= 1'b0;
        end else if (shift_en_s) begin
            shift_r   <= {sdi_d_r, shift_r[WIDTH-1:1]};
            bit_cnt_r <= bit_cnt_r + BC_ONE;
        end else if (extra_set_s) begin
            extra_r   <= 1'b1;
        end else begin
            extra_r   <= extra_r;
        end
    end

    assign load_s = complete_s & (~data_valid_r | data_ready);
    assign drop_s = complete_s & data_valid_r & ~data_ready;

    // Output word, handshake, status and good-frame counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_out_r    <= {WIDTH{1'b0}};
            data_valid_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            overflow_r    <= 1'b0;
            frame_count_r <= {CNT_W{1'b0}};
        end else begin
            frame_err_r <= err_s;
            if (load_s) begin
                data_out_r    <= shift_r;
                data_valid_r  <= 1'b1;
                frame_count_r <= frame_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (data_ready) begin
                data_valid_r  <= 1'b0;
            end else begin
                data_valid_r  <= data_valid_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_overflow) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign data_out    = data_out_r;
    assign data_valid  = data_valid_r;
    assign frame_err   = frame_err_r;
    assign overflow    = overflow_r;
    assign frame_count = frame_count_r;

endmodule
